// File: rtl/fp_normalizer.sv
// Post-add normalizer for IEEE-754 single precision.
// Folds in the adder carry, then left-shifts one bit per cycle until the
// hidden bit is set, the exponent bottoms out (denormal), or the mantissa
// is zero. Handles exponent overflow to infinity. No rounding.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [23:0] mant_in,
  input  logic        carry_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        sign_reg, sign_next;
  logic [23:0] m_reg, m_next;
  logic [7:0]  e_reg, e_next;
  logic [31:0] result_reg, result_next;
  logic        overflow_reg, overflow_next;
  logic        zero_reg, zero_next;

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;

  // Next-state and datapath decisions; every target defaults to hold.
  always_comb begin
    state_next    = state_reg;
    sign_next     = sign_reg;
    m_next        = m_reg;
    e_next        = e_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    zero_next     = zero_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_next = sign_in;
          if (carry_in) begin
            // Carry out means the sum is in [2,4): shift right, bump exponent.
            m_next = {1'b1, mant_in[23:1]};
            e_next = exp_in + 8'd1;
            if (exp_in >= 8'hFE) begin
              // Incremented exponent would reach the all-ones field: infinity.
              state_next    = DONE;
              result_next   = {sign_in, 8'hFF, 23'b0};
              overflow_next = 1'b1;
              zero_next     = 1'b0;
            end else begin
              state_next = NORM;
            end
          end else begin
            m_next     = mant_in;
            e_next     = exp_in;
            state_next = NORM;
          end
        end
      end
      NORM: begin
        if (m_reg == 24'd0) begin
          result_next   = {sign_reg, 31'b0};
          zero_next     = 1'b1;
          overflow_next = 1'b0;
          state_next    = DONE;
        end else if (m_reg[23]) begin
          result_next   = {sign_reg, e_reg, m_reg[22:0]};
          zero_next     = 1'b0;
          overflow_next = 1'b0;
          state_next    = DONE;
        end else if (e_reg <= 8'd1) begin
          // Exponent cannot drop further: emit as denormal (exp field 0).
          result_next   = {sign_reg, 8'h00, m_reg[22:0]};
          zero_next     = 1'b0;
          overflow_next = 1'b0;
          state_next    = DONE;
        end else begin
          m_next = {m_reg[22:0], 1'b0};
          e_next = e_reg - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          // Flags are only meaningful while the result is offered.
          overflow_next = 1'b0;
          zero_next     = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sign_reg     <= 1'b0;
      m_reg        <= 24'd0;
      e_reg        <= 8'd0;
      result_reg   <= 32'd0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sign_reg     <= sign_next;
      m_reg        <= m_next;
      e_reg        <= e_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      zero_reg     <= zero_next;
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed corner vectors, a
// backpressure and mid-operation reset scenario, then random operations
// compared against an arithmetic reference model.
module tb_fp_normalizer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [23:0] mant_in;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  fp_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: count leading zeros, shift as far as the exponent allows.
  function automatic void model(input logic s, input logic [7:0] e, input logic [23:0] m,
                                input logic c, output logic [31:0] r, output logic ov,
                                output logic z, output int lat);
    logic [23:0] mm;
    int ee, lz, k;
    if (c && e >= 8'hFE) begin
      r = {s, 8'hFF, 23'b0}; ov = 1'b1; z = 1'b0; lat = 1;
      return;
    end
    mm = c ? {1'b1, m[23:1]} : m;
    ee = c ? int'(e) + 1 : int'(e);
    ov = 1'b0;
    if (mm == 24'd0) begin
      r = {s, 31'b0}; z = 1'b1; lat = 2;
      return;
    end
    z = 1'b0;
    lz = 0;
    while (!mm[23 - lz]) lz++;
    k = (ee > 1) ? ((lz < ee - 1) ? lz : ee - 1) : 0;
    mm = mm << k;
    ee = ee - k;
    if (mm[23]) r = {s, 8'(ee), mm[22:0]};
    else        r = {s, 8'h00, mm[22:0]};
    lat = 2 + k;
  endfunction

  // One transaction: present, count cycles to out_valid, check, optionally stall, drain.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [23:0] m, input logic c, input int hold,
                        output logic [31:0] obs_res);
    logic [31:0] er;
    logic eo, ez;
    int el, lat;
    logic got;
    model(s, e, m, c, er, eo, ez, el);
    @(posedge clk); #1;
    out_ready = (hold == 0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    sign_in = s; exp_in = e; mant_in = m; carry_in = c; in_valid = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++; #1;
      // Keep in_valid high with junk while busy; it must be ignored.
      sign_in = 1'($urandom); exp_in = 8'($urandom); mant_in = 24'($urandom);
      carry_in = 1'($urandom);
      if (out_valid) got = 1'b1;
    end
    in_valid = 1'b0;
    obs_res = result;
    check({tag, "_latency"}, got ? 32'(lat) : 32'd999, 32'(el));
    check({tag, "_result"}, result, er);
    check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        in_valid = 1'b1; mant_in = 24'($urandom);
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_result"}, result, er);
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_flags"}, {30'd0, overflow, zero}, 32'd0);
    $display("op %s s=%0d e=%h m=%h c=%0d -> %h ovf=%0d zero=%0d lat=%0d (exp %h lat %0d)",
             tag, s, e, m, c, obs_res, eo, ez, lat, er, el);
  endtask

  initial begin
    logic [31:0] r;
    int vcount;
    rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = 8'd0; mant_in = 24'd0;
    carry_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {30'd0, overflow, zero}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op("V1", 1'b0, 8'h80, 24'hC00000, 1'b0, 0, r);
    check("V1_spec", r, 32'h40400000);
    run_op("V2", 1'b0, 8'h7F, 24'h000000, 1'b1, 0, r);
    check("V2_spec", r, 32'h40000000);
    run_op("V3", 1'b0, 8'h85, 24'h000100, 1'b0, 0, r);
    check("V3_spec", r, 32'h3B000000);
    run_op("V4z", 1'b1, 8'h40, 24'h000000, 1'b0, 0, r);
    check("V4z_spec", r, 32'h80000000);
    run_op("V4o", 1'b0, 8'hFE, 24'h123456, 1'b1, 0, r);
    check("V4o_spec", r, 32'h7F800000);
    run_op("V5", 1'b0, 8'h03, 24'h000010, 1'b0, 0, r);
    check("V5_spec", r, 32'h00000040);
    run_op("E0", 1'b1, 8'h00, 24'h400001, 1'b0, 0, r);
    run_op("E0z", 1'b0, 8'h00, 24'h000000, 1'b0, 0, r);
    run_op("OvFF", 1'b1, 8'hFF, 24'h800000, 1'b1, 0, r);
    run_op("V6bp", 1'b1, 8'h85, 24'h000100, 1'b0, 5, r);

    // Reset in the middle of a long normalization.
    @(posedge clk); #1;
    out_ready = 1'b1;
    sign_in = 1'b0; exp_in = 8'h85; mant_in = 24'h000100; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("V6_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("V6_rst_out_valid", 32'(out_valid), 32'd0);
    check("V6_rst_result", result, 32'd0);
    check("V6_rst_in_ready_after", 32'(in_ready), 32'd1);
    vcount = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    check("V6_no_stale_valid", 32'(vcount), 32'd0);
    $display("op V6rst abandoned, stray out_valid cycles=%0d", vcount);

    // Random operations; leading zeros spread by a random right shift.
    for (int i = 0; i < 200; i++) begin
      logic [23:0] rm;
      logic [7:0] re;
      rm = 24'($urandom) >> $urandom_range(0, 24);
      re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) :
           ($urandom_range(0, 5) == 0) ? 8'($urandom_range(8'hFC, 8'hFF)) : 8'($urandom);
      run_op($sformatf("R%0d", i), 1'($urandom), re, rm, 1'($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 2)), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_normalizer.md
FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 The block SHALL have one clock, clk; reset, rst, SHALL be synchronous and active-high.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk        in   1   rising-edge clock
  rst        in   1   synchronous active-high reset
  in_valid   in   1   upstream adder result valid
  in_ready   out  1   block can accept an input
  sign_in    in   1   result sign from sign logic
  exp_in     in   8   biased exponent of larger operand
  mant_in    in   24  raw mantissa sum/difference magnitude (bit 23 = hidden bit position)
  carry_in   in   1   carry out of 24-bit mantissa add
  out_valid  out  1   result valid
  out_ready  in   1   downstream accepts result
  result     out  32  packed IEEE-754 single {sign, exp[7:0], frac[22:0]}
  overflow   out  1   result saturated to infinity
  zero       out  1   result is signed zero
REQ-003 The block SHALL have no parameters.

Function
REQ-004 FSM states SHALL be IDLE, NORM, DONE; in_ready SHALL equal (state==IDLE) && !rst.
REQ-005 In IDLE, on in_valid && in_ready, the block SHALL register sign_in, and load M/E: if carry_in, M = {1'b1, mant_in[23:1]} (LSB truncated) and E = exp_in+1; else M = mant_in, E = exp_in; next state NORM.
REQ-006 If carry_in and exp_in >= 8'hFE at acceptance, next state SHALL be DONE with result = {sign_in, 8'hFF, 23'b0}, overflow=1, zero=0.
REQ-007 In NORM, each cycle, priority order:
  a) M == 0 -> result = {sign, 31'b0}, zero=1 -> DONE;
  b) M[23] == 1 -> result = {sign, E, M[22:0]} -> DONE;
  c) E <= 1 and M[23]==0 -> denormal: result = {sign, 8'h00, M[22:0]} -> DONE;
  d) otherwise M <= M<<1, E <= E-1, stay in NORM.
REQ-008 Left shift SHALL be exactly one bit per cycle; no rounding is performed.
REQ-009 In DONE, out_valid SHALL be 1 and result/overflow/zero SHALL be held stable until out_valid && out_ready; then next state IDLE with out_valid=0.
REQ-010 Latency: input accepted at edge N -> out_valid high after edge N+2+k, k = left shifts performed (0..22); overflow case out_valid after edge N+1.
REQ-011 out_valid and in_ready SHALL never be high simultaneously; inputs during NORM/DONE SHALL be ignored.
REQ-012 overflow and zero SHALL be 0 whenever out_valid is 0, and updated only on the DONE-entry edge.
REQ-013 exp_in == 0 with carry_in == 0 SHALL take REQ-007 path c (or a) in the first NORM cycle.

Reset
REQ-014 While rst is high at a clock edge: state SHALL go IDLE, out_valid=0, result=32'h0, overflow=0, zero=0, internal M/E cleared; in_ready=0 while rst high.
REQ-015 Reset asserted in NORM or DONE SHALL abandon the operation; no out_valid pulse for it SHALL follow.

Verification
REQ-016 The bench SHALL cover:
  V1 already normalized: sign 0, exp 8'h80, mant 24'hC00000, carry 0, out_ready=1 -> result 32'h40400000, out_valid 2 cycles after accept.
  V2 carry: exp 8'h7F, mant 24'h000000, carry 1 -> result 32'h40000000 (2.0), overflow 0.
  V3 leading zeros: exp 8'h85, mant 24'h000100, carry 0 -> 15 shifts, result 32'h3B000000, out_valid 17 cycles after accept.
  V4 zero: sign 1, mant 0, carry 0 -> result 32'h80000000, zero=1; overflow: exp 8'hFE, carry 1 -> 32'h7F800000, overflow=1, out_valid 1 cycle after accept.
  V5 denormal: exp 8'h03, mant 24'h000010, carry 0 -> 2 shifts then E=1 -> result 32'h00000040 (exp field 0).
  V6 backpressure/reset: out_ready=0 for 5 cycles holds result, in_ready=0; rst asserted mid-NORM -> out_valid stays 0, in_ready=1 cycle after rst drops.
